// File: rtl/button_encoder_4x2.sv
// button_encoder_4x2
//
// Debounced 4-to-2 encoder for four active-low push-buttons. The raw button
// bus is synchronized through two flops, debounced with a candidate register
// and a stability counter, and the accepted (stable) state is decoded into a
// 2-bit index plus status flags. A one-cycle strobe marks each newly accepted
// single press.
//
// There is no valid/ready handshake here. o_press is a plain one-cycle
// strobe. o_code is only meaningful on or after a strobe, and it holds
// between presses.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new state (>= 1)
//
// Ports:
//   i_clk      in   system clock, rising edge
//   i_reset_n  in   synchronous active-low reset
//   i_button   in   [3:0] raw asynchronous buttons, 0 = pressed (one-cold)
//   o_code     out  [1:0] index of the last accepted single press
//   o_valid    out  debounced state is exactly one pressed button
//   o_multi    out  debounced state has two or more pressed buttons
//   o_press    out  one-cycle strobe on acceptance of a new single press
module button_encoder_4x2 #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_button,
  output logic [1:0] o_code,
  output logic       o_valid,
  output logic       o_multi,
  output logic       o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    cand;
  logic [3:0]    stable;
  logic [CW-1:0] cnt;

  // Single-press recognition of the candidate, used on the accept edge.
  logic          cand_single;
  logic [1:0]    cand_index;

  always_comb begin
    cand_single = 1'b1;
    cand_index  = 2'd0;
    case (cand)
      4'b1110: cand_index = 2'd0;
      4'b1101: cand_index = 2'd1;
      4'b1011: cand_index = 2'd2;
      4'b0111: cand_index = 2'd3;
      default: cand_single = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1   <= 4'b1111;
      sync2   <= 4'b1111;
      cand    <= 4'b1111;
      stable  <= 4'b1111;
      cnt     <= '0;
      o_code  <= 2'd0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_button;
      sync2   <= sync1;
      o_press <= 1'b0;

      if (sync2 != cand) begin
        // Any movement restarts the window, so short glitches never mature.
        cand <= sync2;
        cnt  <= '0;
      end else if (cand != stable) begin
        if (cnt == CNT_LAST) begin
          // Accept: only a single-press pattern updates the code and strobes.
          stable <= cand;
          cnt    <= '0;
          if (cand_single) begin
            o_code  <= cand_index;
            o_press <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Candidate already matches the accepted state: nothing to time.
        cnt <= '0;
      end
    end
  end

  // Status flags decode the accepted state by counting pressed (zero) bits.
  logic [3:0] pressed;
  assign pressed = ~stable;
  assign o_valid = ($countones(pressed) == 1);
  assign o_multi = ($countones(pressed) > 1);

endmodule

// File: tb/tb_button_encoder_4x2.sv
// Testbench for button_encoder_4x2 with DEBOUNCE_CYCLES = 4.
// Directed table of hold segments, hand-written timing sequences, and a
// randomized phase; every edge is also scored against a history-window model.
module tb_button_encoder_4x2;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] button;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       press;

  always #5 clk = ~clk;

  button_encoder_4x2 #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_button  (button),
    .o_code    (code),
    .o_valid   (valid),
    .o_multi   (multi),
    .o_press   (press)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A new state is accepted once the same raw sample has been seen on D+1
  // consecutive edges, counted from two edges back (synchronizer delay), and
  // it differs from the currently accepted state. Reset forgets all history.
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic [1:0] m_code;
  logic       m_press;

  function automatic int zeros(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) n++;
    return n;
  endfunction

  task automatic model_edge(input logic rst_n, input logic [3:0] b);
    logic       same;
    logic [3:0] dropped;
    if (!rst_n) begin
      hist.delete();
      repeat (D + 3) hist.push_back(4'b1111);
      m_stable = 4'b1111;
      m_code   = 2'd0;
      m_press  = 1'b0;
    end else begin
      hist.push_back(b);
      dropped = hist.pop_front();
      m_press = 1'b0;
      same    = 1'b1;
      for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) same = 1'b0;
      if (same && hist[0] != m_stable) begin
        m_stable = hist[0];
        if (zeros(m_stable) == 1) begin
          for (int i = 0; i < 4; i++) if (!m_stable[i]) m_code = 2'(i);
          m_press = 1'b1;
        end
      end
    end
    exp_q.push_back({m_code, zeros(m_stable) == 1, zeros(m_stable) >= 2, m_press});
  endtask

  // ---------------- driver ----------------
  // Inputs are held across the edge; outputs are sampled 1 time unit later.
  task automatic tick();
    logic       rst_s;
    logic [3:0] b_s;
    logic [4:0] e;
    rst_s = reset_n;
    b_s   = button;
    @(posedge clk);
    model_edge(rst_s, b_s);
    #1;
    e = exp_q.pop_front();
    check("scoreboard", {code, valid, multi, press}, e);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] button;
    int         cycles;
    int         presses;
    logic [1:0] code;
    logic       valid;
    logic       multi;
  } vec_t;

  vec_t tbl[10];

  int first;
  int n;
  int r;
  int len;
  logic [3:0] one;

  initial begin
    tbl[0] = '{4'b1101,  3, 0, 2'b10, 1'b0, 1'b0};  // glitch shorter than window
    tbl[1] = '{4'b1111, 10, 0, 2'b10, 1'b0, 1'b0};
    tbl[2] = '{4'b0111, 10, 1, 2'b11, 1'b1, 1'b0};
    tbl[3] = '{4'b0110, 10, 0, 2'b11, 1'b0, 1'b1};  // multi-press, code holds
    tbl[4] = '{4'b1111, 10, 0, 2'b11, 1'b0, 1'b0};  // release, no pulse
    tbl[5] = '{4'b1110, 10, 1, 2'b00, 1'b1, 1'b0};
    tbl[6] = '{4'b1101, 10, 1, 2'b01, 1'b1, 1'b0};  // single to different single
    tbl[7] = '{4'b1111, 10, 0, 2'b01, 1'b0, 1'b0};
    tbl[8] = '{4'b0000, 10, 0, 2'b01, 1'b0, 1'b1};
    tbl[9] = '{4'b1111, 10, 0, 2'b01, 1'b0, 1'b0};

    // Reset held with a button pressed.
    reset_n = 1'b0;
    button  = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_code",  code,  0);
      check("reset_valid", valid, 0);
      check("reset_multi", multi, 0);
      check("reset_press", press, 0);
    end
    reset_n = 1'b1;
    button  = 4'b1111;
    repeat (5) tick();

    // Clean press: pulse on edge D+3, once, no auto-repeat.
    button = 4'b1011;
    first  = 0;
    n      = 0;
    for (int e = 1; e <= 27; e++) begin
      tick();
      if (press) begin
        n++;
        if (first == 0) first = e;
      end
    end
    check("clean_press_edge",  first, 7);
    check("clean_press_count", n, 1);
    check("clean_press_code",  code, 2'b10);
    check("clean_press_valid", valid, 1);

    button = 4'b1111;
    repeat (10) tick();

    for (int t = 0; t < 10; t++) begin
      button = tbl[t].button;
      n = 0;
      repeat (tbl[t].cycles) begin
        tick();
        if (press) n++;
      end
      check("tbl_presses", n, tbl[t].presses);
      check("tbl_code",    code,  tbl[t].code);
      check("tbl_valid",   valid, tbl[t].valid);
      check("tbl_multi",   multi, tbl[t].multi);
    end

    // Bounce: 1110/1111 every 2 cycles, then hold 1110.
    n = 0;
    for (int s = 0; s < 6; s++) begin
      button = (s % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (2) begin
        tick();
        if (press) n++;
      end
    end
    check("bounce_early_press", n, 0);
    button = 4'b1110;
    first  = 0;
    n      = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (press) begin
        n++;
        if (first == 0) first = e;
      end
    end
    check("bounce_press_edge",  first, 7);
    check("bounce_press_count", n, 1);
    check("bounce_code",        code, 2'b00);

    // Reset in the middle of a count.
    button = 4'b1111;
    repeat (10) tick();
    button = 4'b1101;
    n = 0;
    repeat (5) begin
      tick();
      if (press) n++;
    end
    reset_n = 1'b0;
    tick();
    if (press) n++;
    check("midreset_early_press", n, 0);
    check("midreset_code_cleared", code, 2'b00);
    reset_n = 1'b1;
    first = 0;
    n     = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (press) begin
        n++;
        if (first == 0) first = e;
      end
    end
    check("midreset_press_edge",  first, 7);
    check("midreset_press_count", n, 1);
    check("midreset_code",        code, 2'b01);

    // Randomized segments scored by the model on every edge.
    one = 4'b0001;
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 5)      button = ~(one << (r % 4));
      else if (r < 7) button = 4'b1111;
      else            button = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 8);
      repeat (len) tick();
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end

    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
